// File: rtl/ni_vc_packet_lock_ctrl.sv
// ni_vc_packet_lock_ctrl: builds VN x VC arbiter requests, locks the granted VC until its tail flit is sent.
// Optional sticky credit-overflow detection under NI_CREDIT_OVERFLOW_CHECK_EN.
module ni_vc_packet_lock_ctrl #(
  parameter int NUM_VC      = 1,
  parameter int NUM_VN      = 3,
  parameter int FLIT_SIZE   = 64,
  parameter int MAX_CREDITS = 4,
  localparam int N  = NUM_VC * NUM_VN,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(MAX_CREDITS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_p,
  input  logic [N-1:0]           req_in,
  input  logic [N-1:0]           tail_in,
  input  logic [N*FLIT_SIZE-1:0] flits_in,
  input  logic [N-1:0]           credit_in,
  output logic [N-1:0]           arb_req_out,
  input  logic [N-1:0]           arb_grant_vec,
  input  logic [IW-1:0]          arb_grant_id,
  output logic [N-1:0]           pop_out,
  output logic [N-1:0]           grants_out,
  output logic [FLIT_SIZE-1:0]   flit_out,
  output logic                   flit_valid_out,
  output logic [IW-1:0]          flit_vc_out,
  output logic                   err_credit_ovf
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [IW-1:0] locked_id, sel;
  logic [N-1:0] avail, onehot;
  logic fire;
  logic [CW-1:0] credit_cnt [N];
  always_comb begin
    avail = '0;
    for (int i = 0; i < N; i++) avail[i] = req_in[i] && credit_cnt[i] != '0;
    sel = (state == IDLE) ? arb_grant_id : locked_id;
    fire = !rst_p && avail[sel] && (state == LOCKED || |arb_grant_vec);
    onehot = N'(1) << sel;
    arb_req_out = (rst_p || state == LOCKED) ? '0 : avail;
    pop_out = fire ? onehot : '0;
    state_nx = fire ? (tail_in[sel] ? IDLE : LOCKED) : state;
  end
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state <= IDLE;
      locked_id <= '0;
      flit_out <= '0;
      flit_valid_out <= 1'b0;
      flit_vc_out <= '0;
      grants_out <= '0;
    end else begin
      state <= state_nx;
      flit_valid_out <= fire;
      grants_out <= (fire && tail_in[sel]) ? onehot : '0;
      if (fire) begin
        locked_id <= sel;
        flit_out <= flits_in[int'(sel)*FLIT_SIZE +: FLIT_SIZE];
        flit_vc_out <= sel;
      end
    end
  end
  // simultaneous pop and return cancel; returns saturate at MAX_CREDITS
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_p) credit_cnt[i] <= CW'(MAX_CREDITS);
      else if (pop_out[i] && !credit_in[i]) credit_cnt[i] <= credit_cnt[i] - CW'(1);
      else if (!pop_out[i] && credit_in[i] && credit_cnt[i] != CW'(MAX_CREDITS)) credit_cnt[i] <= credit_cnt[i] + CW'(1);
    end
  end
`ifdef NI_CREDIT_OVERFLOW_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst_p) err_credit_ovf <= 1'b0;
    else for (int i = 0; i < N; i++)
      if (credit_in[i] && !pop_out[i] && credit_cnt[i] == CW'(MAX_CREDITS)) err_credit_ovf <= 1'b1;
  end
`else
  assign err_credit_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_ni_vc_packet_lock_ctrl.sv
// tb_ni_vc_packet_lock_ctrl: directed checks of request gating, packet locking, credits and reset.
module tb_ni_vc_packet_lock_ctrl;
  logic clk = 0, rst_p = 1;
  logic [2:0] req_in = 0, tail_in = 0, credit_in = 0, arb_req_out, arb_grant_vec, pop_out, grants_out;
  logic [191:0] flits_in = 0;
  logic [1:0] arb_grant_id, flit_vc_out;
  logic [63:0] flit_out;
  logic flit_valid_out, err_credit_ovf;
  int ptr, n_chk = 0, n_fail = 0;
  bit ovf_en;
  ni_vc_packet_lock_ctrl dut (
    .clk(clk), .rst_p(rst_p), .req_in(req_in), .tail_in(tail_in), .flits_in(flits_in),
    .credit_in(credit_in), .arb_req_out(arb_req_out), .arb_grant_vec(arb_grant_vec),
    .arb_grant_id(arb_grant_id), .pop_out(pop_out), .grants_out(grants_out), .flit_out(flit_out),
    .flit_valid_out(flit_valid_out), .flit_vc_out(flit_vc_out), .err_credit_ovf(err_credit_ovf)
  );
  always #5 clk = ~clk;
  // round-robin arbiter stand-in, token advanced by grants_out
  always_comb begin
    arb_grant_vec = '0;
    arb_grant_id = '0;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (ptr + k) % 3;
      if (arb_grant_vec == '0 && arb_req_out[idx]) begin
        arb_grant_vec[idx] = 1'b1;
        arb_grant_id = 2'(idx);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_p) ptr <= 0;
    else for (int k = 0; k < 3; k++) if (grants_out[k]) ptr <= (k + 1) % 3;
  end
  function automatic logic [63:0] fl(int v, int k);
    return 64'h0123_4567_0000_0000 + 64'(v * 256 + k);
  endfunction
  task automatic set_flits(int k);
    for (int v = 0; v < 3; v++) flits_in[v*64 +: 64] = fl(v, k);
  endtask
  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_flit(string tag, int vc, int k, logic [2:0] g);
    chk({tag, "_valid"}, 64'(flit_valid_out), 1);
    chk({tag, "_vc"}, 64'(flit_vc_out), 64'(vc));
    chk({tag, "_data"}, flit_out, fl(vc, k));
    chk({tag, "_grant"}, 64'(grants_out), 64'(g));
  endtask
  task automatic chk_bubble(string tag);
    chk({tag, "_valid"}, 64'(flit_valid_out), 0);
    chk({tag, "_grant"}, 64'(grants_out), 0);
  endtask
  initial begin
`ifdef NI_CREDIT_OVERFLOW_CHECK_EN
    ovf_en = 1;
`else
    ovf_en = 0;
`endif
    req_in = 3'b111;
    tail_in = 3'b111;
    set_flits(0);
    tick();
    tick();
    chk("rst_req", 64'(arb_req_out), 0);
    chk("rst_pop", 64'(pop_out), 0);
    chk("rst_valid", 64'(flit_valid_out), 0);
    chk("rst_flit", flit_out, 0);
    chk("rst_vc", 64'(flit_vc_out), 0);
    chk("rst_grants", 64'(grants_out), 0);
    chk("rst_err", 64'(err_credit_ovf), 0);
    req_in = 0;
    rst_p = 0;
    tick();
    // single-flit packets on VC0 until credits run out
    req_in = 3'b001;
    tail_in = 3'b001;
    for (int k = 1; k <= 4; k++) begin
      set_flits(k);
      #1;
      chk("t1_req", 64'(arb_req_out), 3'b001);
      chk("t1_pop", 64'(pop_out), 3'b001);
      tick();
      chk_flit("t1", 0, k, 3'b001);
    end
    #1;
    chk("t1_blk_req", 64'(arb_req_out), 0);
    chk("t1_blk_pop", 64'(pop_out), 0);
    tick();
    chk_bubble("t1_blk");
    chk("t1_cnt0", 64'(dut.credit_cnt[0]), 0);
    // pop and return in the same cycle leave the count unchanged
    req_in = 0;
    credit_in = 3'b001;
    tick();
    chk("t4_cnt1", 64'(dut.credit_cnt[0]), 1);
    req_in = 3'b001;
    set_flits(5);
    #1;
    chk("t4_pop", 64'(pop_out), 3'b001);
    tick();
    chk_flit("t4", 0, 5, 3'b001);
    chk("t4_same", 64'(dut.credit_cnt[0]), 1);
    req_in = 0;
    tick();
    chk("t4_inc", 64'(dut.credit_cnt[0]), 2);
    tick();
    tick();
    credit_in = 0;
    chk("t4_full", 64'(dut.credit_cnt[0]), 4);
    // three-flit packet on VC1 while VC0 also requests
    req_in = 3'b011;
    tail_in = 3'b001;
    for (int k = 1; k <= 3; k++) begin
      set_flits(10 + k);
      if (k == 3) tail_in = 3'b011;
      #1;
      chk("t2_req", 64'(arb_req_out), k == 1 ? 3'b011 : 3'b000);
      chk("t2_pop", 64'(pop_out), 3'b010);
      tick();
      chk_flit("t2", 1, 10 + k, k == 3 ? 3'b010 : 3'b000);
    end
    req_in = 0;
    credit_in = 3'b010;
    repeat (3) tick();
    credit_in = 0;
    chk("t2_cnt1", 64'(dut.credit_cnt[1]), 4);
    // VC2 locked, its FIFO empties for two cycles
    req_in = 3'b100;
    tail_in = 3'b000;
    set_flits(20);
    #1;
    chk("t3_pop0", 64'(pop_out), 3'b100);
    tick();
    chk_flit("t3_f0", 2, 20, 3'b000);
    req_in = 3'b011;
    tail_in = 3'b011;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t3_bub_req", 64'(arb_req_out), 0);
      chk("t3_bub_pop", 64'(pop_out), 0);
      tick();
      chk_bubble("t3_bub");
    end
    req_in = 3'b111;
    tail_in = 3'b100;
    set_flits(21);
    #1;
    chk("t3_pop1", 64'(pop_out), 3'b100);
    tick();
    chk_flit("t3_f1", 2, 21, 3'b100);
    req_in = 0;
    credit_in = 3'b100;
    repeat (2) tick();
    credit_in = 0;
    chk("t3_cnt2", 64'(dut.credit_cnt[2]), 4);
    // return to a full counter saturates
    chk("t5_err_pre", 64'(err_credit_ovf), 0);
    credit_in = 3'b010;
    tick();
    credit_in = 0;
    chk("t5_err", 64'(err_credit_ovf), 64'(ovf_en));
    chk("t5_cnt", 64'(dut.credit_cnt[1]), 4);
    tick();
    chk("t5_sticky", 64'(err_credit_ovf), 64'(ovf_en));
    // reset after the first flit of a VC0 packet
    req_in = 3'b001;
    tail_in = 3'b000;
    set_flits(30);
    tick();
    chk_flit("t6_f0", 0, 30, 3'b000);
    rst_p = 1;
    #1;
    chk("t6_rst_req", 64'(arb_req_out), 0);
    chk("t6_rst_pop", 64'(pop_out), 0);
    tick();
    chk("t6_valid", 64'(flit_valid_out), 0);
    chk("t6_flit", flit_out, 0);
    chk("t6_vc", 64'(flit_vc_out), 0);
    chk("t6_grants", 64'(grants_out), 0);
    chk("t6_err", 64'(err_credit_ovf), 0);
    for (int v = 0; v < 3; v++) chk("t6_cnt", 64'(dut.credit_cnt[v]), 4);
    rst_p = 0;
    req_in = 3'b010;
    tail_in = 3'b010;
    set_flits(31);
    #1;
    chk("t6_req", 64'(arb_req_out), 3'b010);
    chk("t6_pop", 64'(pop_out), 3'b010);
    tick();
    chk_flit("t6_f1", 1, 31, 3'b010);
    req_in = 0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
